mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit
// per cycle over WIDTH cycles, then applies the sign correction in a single
// FIX cycle. Signed operations work on magnitudes internally, and the sign
// of each result is recorded when the operation is accepted.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement negation helpers.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic             op_div_r;
  logic             neg_lo_r;     // negate product / quotient in FIX
  logic             neg_hi_r;     // negate remainder in FIX (divide only)
  logic [WIDTH-1:0] opnd_r;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_r;        // high product half / partial remainder
  logic [WIDTH-1:0] q_r;          // multiplier shifting out / quotient shifting in

  logic             accept_s;
  logic             is_div_s;
  logic             is_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic             div_zero_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   mul_pick_s;
  logic [WIDTH:0]   div_shl_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_sub_s;

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // Decode the request and form operand magnitudes.
  always_comb begin
    accept_s    = Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    is_div_s    = Op[1];
    is_signed_s = Op[0];
    a_neg_s     = is_signed_s & busA[WIDTH-1];
    b_neg_s     = is_signed_s & busB[WIDTH-1];
    a_mag_s     = a_neg_s ? neg_w(busA) : busA;
    b_mag_s     = b_neg_s ? neg_w(busB) : busB;
    div_zero_s  = is_div_s && (busB == ZERO_W);
  end

  // One iteration step for both multiply and divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + {1'b0, opnd_r};
    mul_pick_s = q_r[0] ? mul_sum_s : {1'b0, acc_r};
    div_shl_s  = {acc_r, q_r[WIDTH-1]};
    div_ge_s   = (div_shl_s >= {1'b0, opnd_r});
    div_sub_s  = div_shl_s[WIDTH-1:0] - opnd_r;
  end

  // Sign correction and result selection, applied in the FIX cycle.
  always_comb begin
    prod_fix_s = neg_lo_r ? neg_2w({acc_r, q_r}) : {acc_r, q_r};
    quo_fix_s  = neg_lo_r ? neg_w(q_r) : q_r;
    rem_fix_s  = neg_hi_r ? neg_w(acc_r) : acc_r;
    if (op_div_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nx_s = div_zero_s ? ST_DONE : ST_CALC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_FIX;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_FIX:  state_nx_s = ST_DONE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      op_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      opnd_r   <= ZERO_W;
      acc_r    <= ZERO_W;
      q_r      <= ZERO_W;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      HI       <= ZERO_W;
      LO       <= ZERO_W;
      DivZero  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      Busy    <= (state_nx_s == ST_CALC) || (state_nx_s == ST_FIX);
      Done    <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            op_div_r <= is_div_s;
            neg_lo_r <= a_neg_s ^ b_neg_s;
            neg_hi_r <= is_div_s ? a_neg_s : (a_neg_s ^ b_neg_s);
            cnt_r    <= CNT_ZERO;
            if (div_zero_s) begin
              HI      <= busA;
              LO      <= ONES_W;
              DivZero <= 1'b1;
            end else begin
              DivZero <= 1'b0;
              acc_r   <= ZERO_W;
              opnd_r  <= is_div_s ? b_mag_s : a_mag_s;
              q_r     <= is_div_s ? a_mag_s : b_mag_s;
            end
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (op_div_r) begin
            acc_r <= div_ge_s ? div_sub_s : div_shl_s[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], div_ge_s};
          end else begin
            acc_r <= mul_pick_s[WIDTH:1];
            q_r   <= {mul_pick_s[0], q_r[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          HI <= res_hi_s;
          LO <= res_lo_s;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): an arithmetic reference
// model with a timing rule, compared against the DUT every cycle, plus
// literal expectations for the worked examples.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  busA;
  logic [W-1:0]  busB;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;
  logic          DivZero;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .busA(busA), .busB(busB), .Busy(Busy), .Done(Done),
    .HI(HI), .LO(LO), .DivZero(DivZero)
  );

  // Free-running clock.
  always #5 Clock = ~Clock;

  typedef struct {
    int          edge_no;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q_exp[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_no = -1;
  int          last_done = -1;
  bit          inflight = 1'b0;
  bit          chk_en = 1'b0;
  logic        busy_m = 1'b0;
  logic        done_m = 1'b0;
  logic        dz_m = 1'b0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Reference arithmetic: full product, truncating division, divide-by-zero rule.
  function automatic void model_op(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
    logic [63:0] p;
    longint      sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = a / b; hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          lo = sq[31:0]; hi = sr[31:0];
        end
      end
    endcase
  endfunction

  // Advance one rising edge and update the model with the inputs seen there.
  task automatic tick();
    logic [31:0] h, l;
    @(posedge Clock);
    edge_no++;
    if (Reset) begin
      q_exp.delete();
      last_done = -1; inflight = 1'b0;
      busy_m = 1'b0; done_m = 1'b0; dz_m = 1'b0; hi_m = 32'd0; lo_m = 32'd0;
    end else begin
      if (Start && edge_no > last_done) begin
        model_op(Op, busA, busB, h, l);
        if (Op[1] && busB == 32'd0) begin
          q_exp.push_back('{edge_no, h, l});
          dz_m = 1'b1; last_done = edge_no; inflight = 1'b0;
        end else begin
          q_exp.push_back('{edge_no + W + 1, h, l});
          dz_m = 1'b0; last_done = edge_no + W + 1; inflight = 1'b1;
        end
      end
      done_m = 1'b0;
      if (q_exp.size() > 0 && q_exp[0].edge_no == edge_no) begin
        hi_m = q_exp[0].hi; lo_m = q_exp[0].lo; done_m = 1'b1;
        void'(q_exp.pop_front());
      end
      busy_m = inflight && (edge_no < last_done);
    end
    @(negedge Clock);
  endtask

  // Issue an operation, scramble the inputs afterwards, then wait n edges.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    Start = 1'b1; Op = op; busA = a; busB = b;
    tick();
    Start = 1'b0; Op = ~op; busA = ~a; busB = b ^ 32'h5A5A_A5A5;
    repeat (n) tick();
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      check("busy",    {31'd0, Busy},    {31'd0, busy_m});
      check("done",    {31'd0, Done},    {31'd0, done_m});
      check("divzero", {31'd0, DivZero}, {31'd0, dz_m});
      check("hi",      HI, hi_m);
      check("lo",      LO, lo_m);
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; busA = 32'd0; busB = 32'd0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    tick();

    // MULTU all-ones squared
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);
    check("lit_multu_hi", HI, 32'hFFFF_FFFE);
    check("lit_multu_lo", LO, 32'h0000_0001);
    check("lit_multu_done", {31'd0, Done}, 32'd1);
    tick();
    check("lit_done_width", {31'd0, Done}, 32'd0);

    // MULT -3 * 5
    run(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, W + 1);
    check("lit_mult_hi", HI, 32'hFFFF_FFFF);
    check("lit_mult_lo", LO, 32'hFFFF_FFF1);
    tick();

    // DIVU 7/2, then DIV -7/2 accepted in the Done cycle
    run(2'b10, 32'd7, 32'd2, W + 1);
    check("lit_divu_lo", LO, 32'd3);
    check("lit_divu_hi", HI, 32'd1);
    run(2'b11, 32'hFFFF_FFF9, 32'd2, W + 1);
    check("lit_div_lo", LO, 32'hFFFF_FFFD);
    check("lit_div_hi", HI, 32'hFFFF_FFFF);
    tick();

    // Most-negative / -1
    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
    check("lit_ovf_lo", LO, 32'h8000_0000);
    check("lit_ovf_hi", HI, 32'h0000_0000);
    check("lit_ovf_dz", {31'd0, DivZero}, 32'd0);
    tick();

    // DIVU 5/0 then MULTU 2*3
    run(2'b10, 32'd5, 32'd0, 0);
    check("lit_dz_hi", HI, 32'd5);
    check("lit_dz_lo", LO, 32'hFFFF_FFFF);
    check("lit_dz_flag", {31'd0, DivZero}, 32'd1);
    check("lit_dz_done", {31'd0, Done}, 32'd1);
    run(2'b00, 32'd2, 32'd3, W + 1);
    check("lit_after_dz_lo", LO, 32'd6);
    check("lit_after_dz_flag", {31'd0, DivZero}, 32'd0);
    tick();

    // Further sign combinations and edge values, checked by the model
    run(2'b11, 32'd7, 32'hFFFF_FFFE, W + 1);
    run(2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, W + 1);
    run(2'b01, 32'h8000_0000, 32'h8000_0000, W + 1);
    run(2'b01, 32'h1234_5678, 32'hFEDC_BA98, W + 2);
    run(2'b10, 32'hFFFF_FFFF, 32'd1, W + 1);
    run(2'b10, 32'hDEAD_BEEF, 32'h0001_0003, W + 2);
    run(2'b11, 32'd0, 32'd5, W + 1);
    run(2'b11, 32'hFFFF_FFF9, 32'd0, 0);
    run(2'b10, 32'h0000_00AB, 32'd0, 0);
    run(2'b00, 32'h0001_0000, 32'h0001_0000, W + 1);
    tick();

    // MULT with ignored Start at edge 5 and Reset at edge 10
    run(2'b01, 32'h0000_0009, 32'hFFFF_FFF0, 4);
    Start = 1'b1; Op = 2'b00; busA = 32'd1; busB = 32'd1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("lit_rst_busy", {31'd0, Busy}, 32'd0);
    check("lit_rst_hi", HI, 32'd0);
    check("lit_rst_lo", LO, 32'd0);
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
